// File: rtl/rv_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// datapath select values, ALU operations, opcodes and the decode helper.
package rv_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic PC_PLUS4 = 1'b0;
    localparam logic PC_ALU   = 1'b1;

    localparam logic [1:0] WB_MDR    = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] IMM_L = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_J = 2'd3;

    localparam logic [1:0] ALUA_REG    = 2'd0;
    localparam logic [1:0] ALUA_ALUOUT = 2'd1;
    localparam logic [1:0] ALUA_PCC    = 2'd2;

    localparam logic [1:0] ALUB_REG  = 2'd0;
    localparam logic [1:0] ALUB_FFFF = 2'd1;
    localparam logic [1:0] ALUB_IMM  = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    // Anything outside the supported subset (including LB/LH/SB/SH) halts.
    function automatic state_t decode_next(input logic [6:0] opcode,
                                           input logic [2:0] funct3);
        state_t nxt;
        nxt = S_HALT;
        case (opcode)
            OP_R:      nxt = S_EXEC_R;
            OP_I:      nxt = S_EXEC_I;
            OP_LOAD:   if (funct3 == F3_WORD) nxt = S_MEM_ADDR;
            OP_STORE:  if (funct3 == F3_WORD) nxt = S_MEM_ADDR;
            OP_BRANCH: if (funct3 == F3_BEQ || funct3 == F3_BNE) nxt = S_BRANCH;
            OP_JAL:    nxt = S_JAL;
            default:   nxt = S_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// ALU operation decode from funct3 and instr[30]; instr[30] selects SUB
// only for register-register ops, and SRA for either shift-right form.
module rv_alu_dec
    import rv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       bit30,
    input  logic       is_rtype,
    output logic [3:0] alusel
);

    always_comb begin
        alusel = ALU_ADD;
        case (funct3)
            3'b000:  alusel = (is_rtype && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  alusel = ALU_SLL;
            3'b010:  alusel = ALU_SLT;
            3'b011:  alusel = ALU_SLTU;
            3'b100:  alusel = ALU_XOR;
            3'b101:  alusel = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  alusel = ALU_OR;
            3'b111:  alusel = ALU_AND;
            default: alusel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_ctl.sv
// Multicycle control FSM for the simple RISC-V core. Define RV_CTL_PERF_EN
// to add the cycle_cnt / instret_cnt performance counters.
module rv_ctl
    import rv_pkg::*;
#(
    parameter int DPWIDTH  = 32,
    parameter int CNTWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DPWIDTH-1:0]  instr,
    input  logic                zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                dmem_wen,
    output logic                pcsourse,
    output logic                pcwrite,
    output logic                pccen,
    output logic                irwrite,
    output logic                regwen,
    output logic                mdrwrite,
    output logic [1:0]          wbsel,
    output logic [1:0]          immsel,
    output logic [1:0]          asel,
    output logic [1:0]          bsel,
    output logic [3:0]          alusel,
    output logic                halted,
`ifdef RV_CTL_PERF_EN
    output logic [CNTWIDTH-1:0] cycle_cnt,
    output logic [CNTWIDTH-1:0] instret_cnt,
`endif
    output state_t              state_dbg
);

    // Memory handshake: *_req rises on entry to the access state and stays
    // high, with dmem_wen stable, until the cycle in which *_ready is seen
    // high; that cycle completes the access. ready is ignored while req is low.

    state_t     state;
    state_t     state_next;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] alu_dec;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign state_dbg    = state;
    assign unused_instr = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

    rv_alu_dec u_alu_dec (
        .funct3   (funct3),
        .bit30    (instr[30]),
        .is_rtype (opcode == OP_R),
        .alusel   (alu_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     state_next = S_FETCH;
            S_FETCH:    if (imem_ready) state_next = S_DECODE;
            S_DECODE:   state_next = decode_next(opcode, funct3);
            S_EXEC_R:   state_next = S_ALU_WB;
            S_EXEC_I:   state_next = S_ALU_WB;
            S_MEM_ADDR: state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (dmem_ready) state_next = S_MEM_WB;
            S_MEM_WR:   if (dmem_ready) state_next = S_FETCH;
            S_ALU_WB:   state_next = S_FETCH;
            S_MEM_WB:   state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JAL:      state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_IDLE;
        endcase
    end

    // Reset forces IDLE asynchronously, so every strobe drops with rst_n.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_wen = 1'b0;
        pcsourse = PC_PLUS4;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        regwen   = 1'b0;
        mdrwrite = 1'b0;
        wbsel    = WB_MDR;
        immsel   = IMM_L;
        asel     = ALUA_REG;
        bsel     = ALUB_REG;
        alusel   = ALU_ADD;
        halted   = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    irwrite = 1'b1;
                    pccen   = 1'b1;
                    pcwrite = 1'b1;
                end
            end
            S_DECODE: begin
                asel   = ALUA_PCC;
                bsel   = ALUB_IMM;
                immsel = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_EXEC_R: begin
                alusel = alu_dec;
            end
            S_EXEC_I: begin
                bsel   = ALUB_IMM;
                alusel = alu_dec;
            end
            S_ALU_WB: begin
                regwen = 1'b1;
                wbsel  = WB_ALUOUT;
            end
            S_MEM_ADDR: begin
                bsel   = ALUB_IMM;
                immsel = (opcode == OP_LOAD) ? IMM_L : IMM_S;
            end
            S_MEM_RD: begin
                dmem_req = 1'b1;
                mdrwrite = dmem_ready;
            end
            S_MEM_WB: begin
                regwen = 1'b1;
                wbsel  = WB_MDR;
            end
            S_MEM_WR: begin
                dmem_req = 1'b1;
                dmem_wen = 1'b1;
            end
            S_BRANCH: begin
                alusel   = ALU_SUB;
                pcsourse = PC_ALU;
                pcwrite  = (funct3 == F3_BNE) ? !zero : zero;
            end
            S_JAL: begin
                regwen   = 1'b1;
                wbsel    = WB_PC;
                pcwrite  = 1'b1;
                pcsourse = PC_ALU;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef RV_CTL_PERF_EN
    // An instruction retires on each edge that returns to FETCH from work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_IDLE && state != S_HALT) begin
                cycle_cnt <= cycle_cnt + CNTWIDTH'(1);
            end
            if (state_next == S_FETCH && state != S_FETCH && state != S_IDLE) begin
                instret_cnt <= instret_cnt + CNTWIDTH'(1);
            end
        end
    end
`else
    localparam int unused_cntwidth = CNTWIDTH;
`endif

endmodule

// File: tb/tb_rv_ctl.sv
// Directed bench for rv_ctl: per-cycle expected control words are queued
// alongside the input vectors and compared one cycle at a time.
module tb_rv_ctl;
    import rv_pkg::*;

    localparam int W = 26;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        imem_ready = 1'b1;
    logic        dmem_ready = 1'b1;
    logic        imem_req, dmem_req, dmem_wen;
    logic        pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite;
    logic [1:0]  wbsel, immsel, asel, bsel;
    logic [3:0]  alusel;
    logic        halted;
    state_t      state_dbg;
`ifdef RV_CTL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    rv_ctl #(.DPWIDTH(32), .CNTWIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_wen   (dmem_wen),
        .pcsourse   (pcsourse),
        .pcwrite    (pcwrite),
        .pccen      (pccen),
        .irwrite    (irwrite),
        .regwen     (regwen),
        .mdrwrite   (mdrwrite),
        .wbsel      (wbsel),
        .immsel     (immsel),
        .asel       (asel),
        .bsel       (bsel),
        .alusel     (alusel),
        .halted     (halted),
`ifdef RV_CTL_PERF_EN
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    logic [W-1:0] obs;
    assign obs = {state_dbg, imem_req, dmem_req, dmem_wen, pcsourse, pcwrite,
                  pccen, irwrite, regwen, mdrwrite, halted,
                  wbsel, immsel, asel, bsel, alusel};

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [34:0]  stim_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // strb order: imem_req dmem_req dmem_wen pcsourse pcwrite pccen irwrite regwen mdrwrite halted
    function automatic logic [W-1:0] ew(input state_t st, input logic [9:0] strb,
                                        input logic [1:0] wb, input logic [1:0] imm,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [3:0] alu);
        return {st, strb, wb, imm, a, b, alu};
    endfunction

    task automatic push(input logic [31:0] ins, input logic ir, input logic dr,
                        input logic z, input logic [W-1:0] e);
        stim_q.push_back({ins, ir, dr, z});
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; applies each vector, checks, moves one cycle.
    task automatic drain(input string tag);
        int cyc;
        logic [34:0] s;
        logic [W-1:0] e;
        cyc = 0;
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            {instr, imem_ready, dmem_ready, zero} = s;
            #1;
            check($sformatf("%s.c%0d", tag, cyc), obs, e);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, ".in_rst"}, obs, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, ".idle"}, obs, ew(S_IDLE, 10'b0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0));
        @(negedge clk);
    endtask

    task automatic push_fetch(input logic [31:0] ins);
        push(ins, 1'b1, 1'b1, 1'b0, ew(S_FETCH, 10'b1000111000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0));
    endtask

    task automatic push_decode(input logic [31:0] ins, input logic [1:0] imm);
        push(ins, 1'b1, 1'b1, 1'b0, ew(S_DECODE, 10'b0, 2'd0, imm, 2'd2, 2'd2, 4'd0));
    endtask

    task automatic push_alu(input logic [31:0] ins, input state_t ex, input logic [1:0] b,
                            input logic [3:0] alu);
        push_fetch(ins);
        push_decode(ins, 2'd2);
        push(ins, 1'b1, 1'b1, 1'b0, ew(ex, 10'b0, 2'd0, 2'd0, 2'd0, b, alu));
        push(ins, 1'b1, 1'b1, 1'b0, ew(S_ALU_WB, 10'b0000000100, 2'd1, 2'd0, 2'd0, 2'd0, 4'd0));
    endtask

    task automatic push_branch(input logic [31:0] ins, input logic z, input logic [9:0] strb);
        push_fetch(ins);
        push_decode(ins, 2'd2);
        push(ins, 1'b1, 1'b1, z, ew(S_BRANCH, strb, 2'd0, 2'd0, 2'd0, 2'd0, 4'd1));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst.ctl", obs, '0);
`ifdef RV_CTL_PERF_EN
        check("rst.cycle_cnt", cycle_cnt, 32'd0);
        check("rst.instret_cnt", instret_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("rel.idle", obs, '0);
        @(negedge clk);

        // ALU ops: add, sub, addi with instr[30]=1 (still ADD), srai
        push_alu(32'h002081B3, S_EXEC_R, 2'd0, 4'd0);
        push_alu(32'h402081B3, S_EXEC_R, 2'd0, 4'd1);
        push_alu(32'h40000093, S_EXEC_I, 2'd2, 4'd0);
        push_alu(32'h4030D093, S_EXEC_I, 2'd2, 4'd7);
        drain("alu");

        // lw x5,8(x1) with two data wait states: 7 cycles
        push_fetch(32'h0080A283);
        push_decode(32'h0080A283, 2'd2);
        push(32'h0080A283, 1'b1, 1'b1, 1'b0, ew(S_MEM_ADDR, 10'b0, 2'd0, 2'd0, 2'd0, 2'd2, 4'd0));
        push(32'h0080A283, 1'b1, 1'b0, 1'b0, ew(S_MEM_RD, 10'b0100000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0));
        push(32'h0080A283, 1'b1, 1'b0, 1'b0, ew(S_MEM_RD, 10'b0100000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0));
        push(32'h0080A283, 1'b1, 1'b1, 1'b0, ew(S_MEM_RD, 10'b0100000010, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0));
        push(32'h0080A283, 1'b1, 1'b1, 1'b0, ew(S_MEM_WB, 10'b0000000100, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0));
        drain("lw");

        // sw x5,8(x1) with one fetch and one data wait state
        push(32'h0050A423, 1'b0, 1'b1, 1'b0, ew(S_FETCH, 10'b1000000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0));
        push_fetch(32'h0050A423);
        push_decode(32'h0050A423, 2'd2);
        push(32'h0050A423, 1'b1, 1'b1, 1'b0, ew(S_MEM_ADDR, 10'b0, 2'd0, 2'd1, 2'd0, 2'd2, 4'd0));
        push(32'h0050A423, 1'b1, 1'b0, 1'b0, ew(S_MEM_WR, 10'b0110000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0));
        push(32'h0050A423, 1'b1, 1'b1, 1'b0, ew(S_MEM_WR, 10'b0110000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0));
        drain("sw");

        // beq taken / not taken, bne taken on zero=0, then jal x1,+8
        push_branch(32'h00208863, 1'b1, 10'b0001100000);
        push_branch(32'h00208863, 1'b0, 10'b0001000000);
        push_branch(32'h00209863, 1'b0, 10'b0001100000);
        push_fetch(32'h008000EF);
        push_decode(32'h008000EF, 2'd3);
        push(32'h008000EF, 1'b1, 1'b1, 1'b0, ew(S_JAL, 10'b0001100100, 2'd2, 2'd0, 2'd0, 2'd0, 4'd0));
        push_fetch(32'h00000000);
        drain("br_jal");

        // lh is outside the supported subset and must halt
        push(32'h00009283, 1'b1, 1'b1, 1'b0, ew(S_DECODE, 10'b0, 2'd0, 2'd2, 2'd2, 2'd2, 4'd0));
        push(32'h00009283, 1'b1, 1'b1, 1'b0, ew(S_HALT, 10'b0000000001, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0));
        drain("lh");
        do_reset("rst_lh");

        // opcode 0x7F: halted with all strobes low for 20 cycles while inputs toggle
        push_fetch(32'h0000007F);
        push_decode(32'h0000007F, 2'd2);
        for (int i = 0; i < 20; i++) begin
            push(32'h0000007F, i[0], i[1], i[2],
                 ew(S_HALT, 10'b0000000001, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0));
        end
        drain("halt");
        do_reset("rst_halt");

        // reset asserted while a store is stalled in MEM_WR
        push_fetch(32'h0050A423);
        push_decode(32'h0050A423, 2'd2);
        push(32'h0050A423, 1'b1, 1'b1, 1'b0, ew(S_MEM_ADDR, 10'b0, 2'd0, 2'd1, 2'd0, 2'd2, 4'd0));
        push(32'h0050A423, 1'b1, 1'b0, 1'b0, ew(S_MEM_WR, 10'b0110000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0));
        drain("sw_abort");
        do_reset("rst_mid");

        // ten back-to-back addi x1,x0,5
        for (int i = 0; i < 10; i++) begin
            push_alu(32'h00500093, S_EXEC_I, 2'd2, 4'd0);
        end
        drain("addi10");
`ifdef RV_CTL_PERF_EN
        check("perf.cycle_cnt", cycle_cnt, 32'd40);
        check("perf.instret_cnt", instret_cnt, 32'd10);
`endif
        push_fetch(32'h00500093);
        drain("addi10_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
